clk_reset_seq: RTL

- Sits directly downstream of the 84 MHz system PLL (27 MHz × 28 / 9).
- Consumes the PLL lock flag and produces:
  - a clean synchronous system reset, released only after lock has been stable;
  - a fractional-rate clock-enable strobe, cpu_clk_en, that paces the emulated TRS-80 CPU bus (nominally 1.774 MHz).
- All downstream logic runs on the PLL output clock and qualifies work with cpu_clk_en.

---
 rtl/clk_reset_pkg.sv | 18 +
 rtl/sync_2ff.sv | 29 ++
 rtl/clk_reset_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/clk_reset_pkg.sv
// Shared types and constants for the PLL-lock reset sequencer and CPU clock-enable generator.
// Optional feature macro CLK_RESET_SEQ_LOSS_CNT_EN is consumed by clk_reset_seq only.
package clk_reset_pkg;

    typedef enum logic [1:0] {
        S_WAIT,
        S_STABLE,
        S_HOLD,
        S_RUN
    } state_e;

    // Phase increment giving ~1.774 MHz strobes from 84 MHz with a 24-bit accumulator
    localparam logic [23:0] CPU_INC_1M774 = 24'd354319;

    localparam int unsigned STABLE_CYCLES_DEF = 1024;
    localparam int unsigned RESET_HOLD_DEF    = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_reset_seq.sv
// Qualifies PLL lock into a clean system reset and paces the CPU bus with a fractional strobe.
// Define CLK_RESET_SEQ_LOSS_CNT_EN to add the saturating loss_cnt output.
module clk_reset_seq
    import clk_reset_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned RESET_HOLD    = RESET_HOLD_DEF,
    parameter int unsigned ACC_W         = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic [ACC_W-1:0] cpu_inc,
    output logic             sys_reset,
    output logic             ready,
    output logic             cpu_clk_en,
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    output logic [7:0]       loss_cnt,
`endif
    output logic             lock_lost
);

    localparam int unsigned CNT_MAX = (STABLE_CYCLES > RESET_HOLD) ? STABLE_CYCLES : RESET_HOLD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic lock_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             cpu_clk_en_q, cpu_clk_en_d;
    logic             lock_lost_q, lock_lost_d;
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    logic [7:0]       loss_cnt_q, loss_cnt_d;
`endif

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = '0;
        cpu_clk_en_d = 1'b0;
        sys_reset_d  = 1'b1;
        ready_d      = 1'b0;
        lock_lost_d  = 1'b0;
        sum          = {1'b0, acc_q} + {1'b0, cpu_inc};

        unique case (state_q)
            S_WAIT: begin
                cnt_d = '0;
                if (lock_s) state_d = S_STABLE;
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // Lock loss is checked first so it wins over the hold expiry
                if (!lock_s) begin
                    state_d     = S_WAIT;
                    cnt_d       = '0;
                    lock_lost_d = 1'b1;
                end else if (cnt_q == CNT_W'(RESET_HOLD - 1)) begin
                    state_d     = S_RUN;
                    cnt_d       = '0;
                    sys_reset_d = 1'b0;
                    ready_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d     = S_WAIT;
                    lock_lost_d = 1'b1;
                end else begin
                    sys_reset_d  = 1'b0;
                    ready_d      = 1'b1;
                    acc_d        = sum[ACC_W-1:0];
                    cpu_clk_en_d = sum[ACC_W];
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_lost_d && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            acc_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            cpu_clk_en_q <= 1'b0;
            lock_lost_q  <= 1'b0;
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
            loss_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            lock_lost_q  <= lock_lost_d;
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
            loss_cnt_q   <= loss_cnt_d;
`endif
        end
    end

    assign sys_reset  = sys_reset_q;
    assign ready      = ready_q;
    assign cpu_clk_en = cpu_clk_en_q;
    assign lock_lost  = lock_lost_q;
`ifdef CLK_RESET_SEQ_LOSS_CNT_EN
    assign loss_cnt   = loss_cnt_q;
`endif

endmodule
